// File: rtl/encode_dst_buf_pkg.sv
// Shared definitions for the encoder destination buffer: default parameters,
// data width and the stream-control state encoding.
package encode_dst_buf_pkg;

    localparam int LZF_WIDTH_DEF    = 20;
    localparam int DEPTH_LOG2_DEF   = 4;
    localparam int AFULL_MARGIN_DEF = 4;
    localparam int DATA_W           = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/encode_dst_buf_if.sv
// Encoder-to-buffer put bus and buffer-to-sink valid/ready stream, bundled.
// The buffer uses the slave view; the environment uses the master view.
interface encode_dst_buf_if;
    import encode_dst_buf_pkg::*;

    logic [DATA_W-1:0] m_dst;
    logic              m_dst_putn;
    logic              m_endn;
    logic              fo_full;
    logic [DATA_W-1:0] dst_data;
    logic              dst_valid;
    logic              dst_ready;
    logic              dst_last;

    modport master (
        output m_dst, m_dst_putn, m_endn, dst_ready,
        input  fo_full, dst_data, dst_valid, dst_last
    );

    modport slave (
        input  m_dst, m_dst_putn, m_endn, dst_ready,
        output fo_full, dst_data, dst_valid, dst_last
    );

endinterface

// File: rtl/encode_dst_fifo.sv
// 64-bit synchronous FIFO with occupancy count; head word is read combinationally
// from storage so it only moves on a pop.
module encode_dst_fifo
    import encode_dst_buf_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                   DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE_C = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   FULL_C    = (DEPTH_LOG2+1)'(DEPTH);

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign push_ok_s = push & (count_r != FULL_C);
    assign pop_ok_s  = pop & (count_r != '0);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/encode_dst_buf.sv
// Destination buffer between the compressor and its sink: holds back the newest
// word until end-of-stream so the final word can be tagged with dst_last.
module encode_dst_buf
    import encode_dst_buf_pkg::*;
#(
    parameter int LZF_WIDTH    = LZF_WIDTH_DEF,
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int AFULL_MARGIN = AFULL_MARGIN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    encode_dst_buf_if.slave      bus,
    output logic [LZF_WIDTH-1:0] dst_cnt,
    output logic                 done,
    output logic                 ovf
);

    localparam logic [DEPTH_LOG2:0]  DEPTH_C   = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]  MARGIN_C  = (DEPTH_LOG2+1)'(AFULL_MARGIN);
    localparam logic [DEPTH_LOG2:0]  ONE_C     = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]  TWO_C     = (DEPTH_LOG2+1)'(2);
    localparam logic [LZF_WIDTH-1:0] CNT_ONE_C = LZF_WIDTH'(1);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [DEPTH_LOG2:0]  count_s;
    logic [DEPTH_LOG2:0]  count_nxt_s;
    logic                 put_s;
    logic                 end_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 drop_s;
    logic                 valid_nxt_s;
    logic                 last_nxt_s;
    logic                 dst_valid_r;
    logic                 dst_last_r;
    logic                 fo_full_r;
    logic                 done_r;
    logic                 ovf_r;
    logic [LZF_WIDTH-1:0] dst_cnt_r;

    assign put_s    = ce & ~bus.m_dst_putn;
    assign end_s    = ce & ~bus.m_endn;
    assign accept_s = (state_r == ST_IDLE) || (state_r == ST_RUN);
    assign push_s   = put_s & accept_s & (count_s != DEPTH_C);
    assign drop_s   = put_s & ~push_s;
    assign pop_s    = ce & dst_valid_r & bus.dst_ready;

    encode_dst_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.m_dst),
        .dout  (bus.dst_data),
        .count (count_s)
    );

    // Occupancy after this cycle, mirrored from the FIFO to precompute outputs.
    always_comb begin
        count_nxt_s = count_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_s + ONE_C;
            2'b01:   count_nxt_s = count_s - ONE_C;
            default: count_nxt_s = count_s;
        endcase
    end

    // Stream-control next state; a put coinciding with end goes straight to drain.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (put_s && end_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if (put_s) begin
                    state_nxt_s = ST_RUN;
                end else if (end_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (end_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (count_nxt_s == '0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // While running the newest word stays hidden; once draining everything shows.
    always_comb begin
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_RUN: begin
                valid_nxt_s = (count_nxt_s >= TWO_C);
            end
            ST_DRAIN: begin
                valid_nxt_s = (count_nxt_s >= ONE_C);
                last_nxt_s  = (count_nxt_s == ONE_C);
            end
            default: begin
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
            end
        endcase
    end

    // Control and output registers; ce low freezes everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            dst_valid_r <= 1'b0;
            dst_last_r  <= 1'b0;
            fo_full_r   <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
            dst_cnt_r   <= '0;
        end else if (ce) begin
            state_r     <= state_nxt_s;
            dst_valid_r <= valid_nxt_s;
            dst_last_r  <= last_nxt_s;
            fo_full_r   <= ((DEPTH_C - count_s) <= MARGIN_C);
            done_r      <= (state_nxt_s == ST_DONE);
            ovf_r       <= ovf_r | drop_s;
            if (state_r == ST_DONE) begin
                dst_cnt_r <= '0;
            end else if (pop_s) begin
                dst_cnt_r <= dst_cnt_r + CNT_ONE_C;
            end
        end
    end

    assign bus.dst_valid = dst_valid_r;
    assign bus.dst_last  = dst_last_r;
    assign bus.fo_full   = fo_full_r;
    assign dst_cnt       = dst_cnt_r;
    assign done          = done_r;
    assign ovf           = ovf_r;

endmodule

// File: tb/tb_encode_dst_buf.sv
// Directed bench for encode_dst_buf: a queue of accepted words is the reference
// for every transfer; stream boundaries and flags are checked at fixed points.
module tb_encode_dst_buf;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [19:0] dst_cnt;
    logic        done;
    logic        ovf;

    encode_dst_buf_if bus();

    encode_dst_buf #(
        .LZF_WIDTH    (20),
        .DEPTH_LOG2   (4),
        .AFULL_MARGIN (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .bus     (bus),
        .dst_cnt (dst_cnt),
        .done    (done),
        .ovf     (ovf)
    );

    int          errors = 0;
    int          checks = 0;
    int          xfers  = 0;
    bit          ended  = 1'b0;
    logic [63:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Score any transfer happening this cycle, then advance one clock.
    task automatic tick();
        logic [63:0] exp_d;
        if (!rst && ce && bus.dst_valid && bus.dst_ready) begin
            chk("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_d = exp_q.pop_front();
                chk("dst_data", bus.dst_data, exp_d);
                chk("dst_last", 64'(bus.dst_last), 64'(ended && (exp_q.size() == 0)));
                xfers++;
            end
        end
        @(negedge clk);
    endtask

    task automatic put(input logic [63:0] d, input bit last_w, input bit accept);
        bus.m_dst      = d;
        bus.m_dst_putn = 1'b0;
        bus.m_endn     = last_w ? 1'b0 : 1'b1;
        if (accept) exp_q.push_back(d);
        if (last_w) ended = 1'b1;
        tick();
        bus.m_dst_putn = 1'b1;
        bus.m_endn     = 1'b1;
    endtask

    task automatic end_pulse();
        bus.m_endn = 1'b0;
        ended      = 1'b1;
        tick();
        bus.m_endn = 1'b1;
    endtask

    task automatic wait_done(input logic [63:0] exp_cnt);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("cnt_at_done", 64'(dst_cnt), exp_cnt);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        ce = 1'b1;
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("cnt_cleared", 64'(dst_cnt), 64'd0);
        ended = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int n;
        rst            = 1'b1;
        ce             = 1'b0;
        bus.m_dst      = 64'd0;
        bus.m_dst_putn = 1'b1;
        bus.m_endn     = 1'b1;
        bus.dst_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset takes effect with ce low.
        chk("rst_valid", 64'(bus.dst_valid), 64'd0);
        chk("rst_last", 64'(bus.dst_last), 64'd0);
        chk("rst_fo_full", 64'(bus.fo_full), 64'd0);
        chk("rst_cnt", 64'(dst_cnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        ce  = 1'b1;
        tick();

        // Three words, end with the third.
        bus.dst_ready = 1'b1;
        xfers = 0;
        put(64'h1, 1'b0, 1'b1);
        chk("a_holdback_1", 64'(bus.dst_valid), 64'd0);
        put(64'h2, 1'b0, 1'b1);
        chk("a_valid_2", 64'(bus.dst_valid), 64'd1);
        put(64'h3, 1'b1, 1'b1);
        tick();
        tick();
        chk("a_done", 64'(done), 64'd1);
        chk("a_valid_at_done", 64'(bus.dst_valid), 64'd0);
        chk("a_xfers", 64'(xfers), 64'd3);
        wait_done(64'd3);

        // Single word, end arrives later.
        put(64'hA5, 1'b0, 1'b1);
        chk("b_holdback", 64'(bus.dst_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_holdback_wait", 64'(bus.dst_valid), 64'd0);
        end
        end_pulse();
        chk("b_valid", 64'(bus.dst_valid), 64'd1);
        chk("b_last", 64'(bus.dst_last), 64'd1);
        chk("b_data", bus.dst_data, 64'hA5);
        wait_done(64'd1);

        // Empty stream.
        end_pulse();
        chk("c_done", 64'(done), 64'd1);
        chk("c_valid", 64'(bus.dst_valid), 64'd0);
        wait_done(64'd0);

        // Fill with sink stalled, then overflow by one.
        bus.dst_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            put(64'h100 + 64'(i), 1'b0, 1'b1);
            if (i == 11) chk("d_fo_full_lag", 64'(bus.fo_full), 64'd0);
            if (i == 12) chk("d_fo_full", 64'(bus.fo_full), 64'd1);
        end
        chk("d_ovf_clear", 64'(ovf), 64'd0);
        put(64'h1FF, 1'b0, 1'b0);
        chk("d_ovf_set", 64'(ovf), 64'd1);
        chk("d_head_valid", 64'(bus.dst_valid), 64'd1);
        chk("d_head_stable", bus.dst_data, 64'h100);
        end_pulse();
        bus.dst_ready = 1'b1;
        wait_done(64'd16);

        // 40 words with random stalls and clock-enable gaps.
        xfers = 0;
        sent  = 0;
        n     = 0;
        while (!(ended && done === 1'b1) && n < 3000) begin
            ce            = ($urandom_range(0, 3) != 0);
            bus.dst_ready = 1'($urandom_range(0, 1));
            if (sent < 40 && !bus.fo_full) begin
                bus.m_dst      = {32'hC0DE0000, 32'(sent)};
                bus.m_dst_putn = 1'b0;
                bus.m_endn     = (sent == 39) ? 1'b0 : 1'b1;
                if (ce) begin
                    exp_q.push_back(bus.m_dst);
                    sent++;
                    if (sent == 40) ended = 1'b1;
                end
            end else begin
                bus.m_dst_putn = 1'b1;
                bus.m_endn     = 1'b1;
            end
            tick();
            n++;
        end
        bus.m_dst_putn = 1'b1;
        bus.m_endn     = 1'b1;
        bus.dst_ready  = 1'b1;
        chk("e_xfers", 64'(xfers), 64'd40);
        wait_done(64'd40);

        // Reset with five words buffered discards them.
        bus.dst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(64'h500 + 64'(i), 1'b0, 1'b1);
        end
        chk("f_valid_before", 64'(bus.dst_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("f_valid", 64'(bus.dst_valid), 64'd0);
        chk("f_last", 64'(bus.dst_last), 64'd0);
        chk("f_done", 64'(done), 64'd0);
        chk("f_fo_full", 64'(bus.fo_full), 64'd0);
        chk("f_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        ended = 1'b0;
        bus.dst_ready = 1'b1;
        put(64'hBEEF, 1'b1, 1'b1);
        chk("f_new_valid", 64'(bus.dst_valid), 64'd1);
        chk("f_new_last", 64'(bus.dst_last), 64'd1);
        chk("f_new_data", bus.dst_data, 64'hBEEF);
        wait_done(64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
